// File: rtl/frame_align_ctrl_if.sv
// rtl/frame_align_ctrl_if.sv - Frame alignment controller status/control bundle
//
// Groups the alignment control and status signals of frame_align_ctrl.
//   start    : starts or restarts an alignment attempt (sampled every cycle)
//   frame    : word from the frame-channel deserializer
//   bitslip  : one-cycle slip pulse to all deserializers
//   locked   : alignment achieved
//   fail     : attempt exhausted without lock, sticky until start
//   busy     : search in progress
//   slip_cnt : slips issued in the current attempt
// master drives start/frame and observes status; slave is the controller side.
interface frame_align_ctrl_if #(
  parameter int WIDTH = 12
);
  logic             start;
  logic [WIDTH-1:0] frame;
  logic             bitslip;
  logic             locked;
  logic             fail;
  logic             busy;
  logic [7:0]       slip_cnt;

  modport master (
    output start, frame,
    input  bitslip, locked, fail, busy, slip_cnt
  );

  modport slave (
    input  start, frame,
    output bitslip, locked, fail, busy, slip_cnt
  );
endinterface

// File: rtl/frame_align_ctrl.sv
// rtl/frame_align_ctrl.sv - Word-alignment controller for the ADC LVDS receive path
//
// Watches the frame-channel deserializer word and issues shared bitslip pulses
// until the word equals PATTERN, then monitors for sustained loss of lock and
// re-searches automatically.
// Ports:
//   clkdiv : divided clock, all logic on its rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : frame_align_ctrl_if.slave (start, frame in; bitslip, locked,
//            fail, busy, slip_cnt out, all outputs registered)
module frame_align_ctrl #(
  parameter int               WIDTH       = 12,
  parameter logic [WIDTH-1:0] PATTERN     = 12'hFC0,
  parameter int               SLIP_WAIT   = 4,
  parameter int               MATCH_COUNT = 16,
  parameter int               MAX_SLIPS   = 12,
  parameter int               LOSS_COUNT  = 4
) (
  input  logic                clkdiv,
  input  logic                rst_n,
  frame_align_ctrl_if.slave   bus
);

  localparam int WW = $clog2(SLIP_WAIT + 1);
  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_SLIP,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [MW-1:0] match_cnt;
  logic [LW-1:0] miss_cnt;
  logic          match;

  // Compared combinationally; the result only feeds state and counters.
  assign match = (bus.frame == PATTERN);

  always_ff @(posedge clkdiv or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      match_cnt    <= '0;
      miss_cnt     <= '0;
      bus.bitslip  <= 1'b0;
      bus.locked   <= 1'b0;
      bus.fail     <= 1'b0;
      bus.busy     <= 1'b0;
      bus.slip_cnt <= 8'd0;
    end else begin
      // Pulse is only ever raised for the single cycle spent in SLIP.
      bus.bitslip <= 1'b0;
      if (bus.start) begin
        state        <= S_WAIT;
        wait_cnt     <= '0;
        match_cnt    <= '0;
        miss_cnt     <= '0;
        bus.locked   <= 1'b0;
        bus.fail     <= 1'b0;
        bus.busy     <= 1'b1;
        bus.slip_cnt <= 8'd0;
      end else begin
        case (state)
          S_IDLE: begin
          end

          // Deserializers need time to settle after start or a slip.
          S_WAIT: begin
            if (wait_cnt == WW'(SLIP_WAIT - 1)) begin
              state    <= S_CHECK;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end

          S_CHECK: begin
            if (match) begin
              if (match_cnt == MW'(MATCH_COUNT - 1)) begin
                state      <= S_LOCKED;
                match_cnt  <= '0;
                miss_cnt   <= '0;
                bus.locked <= 1'b1;
                bus.busy   <= 1'b0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else if (bus.slip_cnt < 8'(MAX_SLIPS)) begin
              state       <= S_SLIP;
              match_cnt   <= '0;
              bus.bitslip <= 1'b1;
            end else begin
              state     <= S_FAIL;
              match_cnt <= '0;
              bus.fail  <= 1'b1;
              bus.busy  <= 1'b0;
            end
          end

          S_SLIP: begin
            state        <= S_WAIT;
            wait_cnt     <= '0;
            bus.slip_cnt <= bus.slip_cnt + 8'd1;
          end

          // Isolated bad words are tolerated; a run of LOSS_COUNT restarts the search.
          S_LOCKED: begin
            if (match) begin
              miss_cnt <= '0;
            end else if (miss_cnt == LW'(LOSS_COUNT - 1)) begin
              state        <= S_WAIT;
              wait_cnt     <= '0;
              match_cnt    <= '0;
              miss_cnt     <= '0;
              bus.locked   <= 1'b0;
              bus.busy     <= 1'b1;
              bus.slip_cnt <= 8'd0;
            end else begin
              miss_cnt <= miss_cnt + 1'b1;
            end
          end

          S_FAIL: begin
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_align_ctrl.sv
// tb/tb_frame_align_ctrl.sv - Self-checking bench for frame_align_ctrl
module tb_frame_align_ctrl;

  logic clkdiv = 1'b0;
  logic rst_n  = 1'b0;

  frame_align_ctrl_if #(.WIDTH(12)) bus ();

  frame_align_ctrl dut (
    .clkdiv (clkdiv),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clkdiv = ~clkdiv;

  typedef struct {
    string       name;
    logic [11:0] base;
    int          exp_locked;
    int          exp_fail;
    int          exp_slips;
    int          exp_latency;
  } vec_t;

  vec_t vecs[6];

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          c0 = 0;
  int          n = 0;
  int          pulses = 0;
  int          last_pulse = -1;
  int          gap_err = 0;
  int          consec_err = 0;
  int          rot = 0;
  int          nz = 0;
  logic        prev_slip = 1'b0;
  logic [11:0] base_w = 12'h000;

  function automatic logic [11:0] rotl12(input logic [11:0] v, input int r);
    int k;
    k = r % 12;
    if (k == 0) return v;
    return (v << k) | (v >> (12 - k));
  endfunction

  // {locked, fail, busy, bitslip, slip_cnt}
  function automatic int out_word();
    return int'({20'd0, bus.locked, bus.fail, bus.busy, bus.bitslip, bus.slip_cnt});
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  // One cycle: advance to the next falling edge, then model the deserializer
  // rotating the frame word by 2 bits for every observed bitslip pulse.
  task automatic tick();
    @(negedge clkdiv);
    cyc++;
    if (bus.bitslip) begin
      if (prev_slip) consec_err++;
      if (last_pulse >= 0 && (cyc - last_pulse) != 6) gap_err++;
      last_pulse = cyc;
      pulses++;
      rot += 2;
      bus.frame = rotl12(base_w, rot);
    end
    prev_slip = bus.bitslip;
  endtask

  task automatic start_run(input logic [11:0] b);
    base_w     = b;
    rot        = 0;
    pulses     = 0;
    last_pulse = -1;
    gap_err    = 0;
    consec_err = 0;
    bus.frame  = b;
    bus.start  = 1'b1;
    tick();
    c0        = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    n = 0;
    while (!(bus.locked || bus.fail) && n < budget) begin
      tick();
      n = cyc - c0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"aligned",     12'hFC0, 1, 0, 0,  20};
    vecs[1] = '{"one_slip",    12'h3F0, 1, 0, 1,  26};
    vecs[2] = '{"three_slips", 12'h03F, 1, 0, 3,  38};
    vecs[3] = '{"exhaust_000", 12'h000, 0, 1, 12, 77};
    vecs[4] = '{"five_slips",  12'hF03, 1, 0, 5,  50};
    vecs[5] = '{"exhaust_aaa", 12'hAAA, 0, 1, 12, 77};

    // Reset and idle
    bus.start = 1'b0;
    bus.frame = 12'hFC0;
    rst_n     = 1'b0;
    repeat (3) tick();
    check("reset_outputs", out_word(), 0);
    rst_n = 1'b1;
    nz = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (out_word() != 0) nz++;
    end
    check("idle_outputs_zero", nz, 0);
    check("idle_no_bitslip", pulses, 0);

    // Table-driven searches
    foreach (vecs[i]) begin
      start_run(vecs[i].base);
      check({vecs[i].name, "_start_clear"}, out_word(), 12'h200);
      wait_done(300);
      check({vecs[i].name, "_latency"}, n, vecs[i].exp_latency);
      check({vecs[i].name, "_locked"}, int'(bus.locked), vecs[i].exp_locked);
      check({vecs[i].name, "_fail"}, int'(bus.fail), vecs[i].exp_fail);
      check({vecs[i].name, "_slip_cnt"}, int'(bus.slip_cnt), vecs[i].exp_slips);
      check({vecs[i].name, "_busy"}, int'(bus.busy), 0);
      repeat (10) tick();
      check({vecs[i].name, "_pulses"}, pulses, vecs[i].exp_slips);
      check({vecs[i].name, "_gap_err"}, gap_err, 0);
      check({vecs[i].name, "_consec_err"}, consec_err, 0);
      check({vecs[i].name, "_hold"}, int'({bus.locked, bus.fail}),
            int'({vecs[i].exp_locked[0], vecs[i].exp_fail[0]}));
    end

    // Loss of lock
    start_run(12'hFC0);
    wait_done(100);
    check("loss_initial_latency", n, 20);
    nz = 0;
    for (int i = 0; i < 3; i++) begin
      bus.frame = 12'h000;
      tick();
      if (!bus.locked) nz++;
    end
    bus.frame = 12'hFC0;
    tick();
    check("loss_three_misses_held", nz, 0);
    check("loss_recovered_locked", int'(bus.locked), 1);
    nz = 0;
    for (int i = 0; i < 3; i++) begin
      bus.frame = 12'h000;
      tick();
      if (!bus.locked) nz++;
    end
    check("loss_misses_1_to_3_locked", nz, 0);
    tick();
    check("loss_4th_miss", out_word(), 12'h200);
    bus.frame = 12'hFC0;
    c0 = cyc;
    wait_done(100);
    check("loss_relock_latency", n, 20);
    check("loss_relock_slip_cnt", int'(bus.slip_cnt), 0);

    // START during SLIP
    start_run(12'h000);
    n = 0;
    while (!bus.bitslip && n < 20) begin
      tick();
      n = cyc - c0;
    end
    check("slip_first_pulse_at", n, 5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_in_slip_clears", out_word(), 12'h200);

    // Asynchronous reset mid-WAIT
    tick();
    #2 rst_n = 1'b0;
    #1 check("reset_mid_wait", out_word(), 0);
    tick();
    rst_n     = 1'b1;
    bus.frame = 12'hFC0;
    nz = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_word() != 0) nz++;
    end
    check("idle_after_reset", nz, 0);

    // Asynchronous reset cuts a slip pulse short
    start_run(12'h000);
    n = 0;
    while (!bus.bitslip && n < 20) begin
      tick();
      n = cyc - c0;
    end
    check("cut_pulse_seen", int'(bus.bitslip), 1);
    #2 rst_n = 1'b0;
    #1 check("cut_pulse_reset", out_word(), 0);
    tick();
    rst_n = 1'b1;

    // START held high
    bus.frame = 12'hFC0;
    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("start_held_wait", out_word(), 12'h200);
    bus.start = 1'b0;
    c0 = cyc;
    wait_done(100);
    check("start_held_latency", n, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_align_ctrl.md
# frame_align_ctrl

Word-alignment controller for the ADC LVDS receive path. Runs in the divided-clock domain, watches the 12-bit word from the frame-clock channel's 1x12 DDR deserializer and issues BITSLIP pulses, shared by all data-channel deserializers, until the frame word equals the expected pattern. It reports lock and failure status and re-aligns automatically after sustained loss of lock.

## Interface
Parameters:
- WIDTH, 12: deserialized word width.
- PATTERN, 12'hFC0: expected frame word when aligned.
- SLIP_WAIT, 4: settle cycles after START or any BITSLIP before FRAME is sampled (≥1).
- MATCH_COUNT, 16: consecutive matches required to lock (≥1).
- MAX_SLIPS, 12: slips allowed per attempt before FAIL (≤255).
- LOSS_COUNT, 4: consecutive mismatches while locked that drop lock (≥1).

Ports:
- CLKDIV  in  1  divided clock; all logic on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  starts or restarts alignment; sampled every cycle.
- FRAME  in  WIDTH  frame-channel deserializer output.
- BITSLIP  out  1  one-cycle slip pulse to all deserializers; registered.
- LOCKED  out  1  alignment achieved.
- FAIL  out  1  attempt exhausted without lock; sticky until START.
- BUSY  out  1  high in WAIT, CHECK and SLIP.
- SLIP_CNT  out  8  slips issued in the current attempt.

## Operation
- States: IDLE, WAIT, CHECK, SLIP, LOCKED, FAIL.
- Reset: state IDLE. All outputs and the internal counters (wait, match, miss) are 0.
- START=1 in any state, with priority over all other transitions: go to WAIT. Clear SLIP_CNT, the wait, match and miss counters, LOCKED and FAIL.
- IDLE: hold. Stay here until START, whatever FRAME is.
- WAIT: count SLIP_WAIT cycles, then go to CHECK. FRAME is ignored.
- CHECK: compare FRAME==PATTERN on every cycle.
  - On a match, increment the match counter. On the MATCH_COUNT-th consecutive match, go to LOCKED.
  - On a mismatch with SLIP_CNT<MAX_SLIPS, clear the match counter and go to SLIP.
  - On a mismatch with SLIP_CNT==MAX_SLIPS, go to FAIL.
- SLIP: BITSLIP=1 for exactly this one cycle. Increment SLIP_CNT, then go to WAIT.
- LOCKED: LOCKED=1 and SLIP_CNT is frozen.
  - A match clears the miss counter.
  - On the LOSS_COUNT-th consecutive mismatch, clear LOCKED, SLIP_CNT and the counters, and go to WAIT (automatic re-search).
- FAIL: FAIL=1 and BITSLIP=0. Stay here until START.
- BITSLIP is never high on two consecutive cycles. At least SLIP_WAIT+1 non-slip cycles separate any two pulses.
- START held high keeps the block in WAIT, restarted every cycle. Alignment proceeds after START falls.
- RST_N asserted mid-search forces IDLE immediately. A BITSLIP pulse in progress is cut short asynchronously.

## Timing
- START sampled at edge k: state is WAIT after edge k. CHECK is entered at edge k+SLIP_WAIT.
- Already-aligned input: LOCKED rises at edge k+SLIP_WAIT+MATCH_COUNT (k+20 with defaults). BITSLIP stays 0.
- Mismatch sampled at edge e: BITSLIP is high from edge e to edge e+1. FRAME is next sampled at edge e+1+SLIP_WAIT+1. Each failed position costs SLIP_WAIT+2 cycles (6 with defaults).
- Exhaustion: FAIL rises at the edge sampling the mismatch after the MAX_SLIPS-th slip. BUSY falls on the same edge.
- Loss of lock: LOCKED falls at the edge sampling the LOSS_COUNT-th consecutive mismatch.
- Data path: FRAME is compared combinationally and registered only into state and counters. No extra pipeline stage.

## Test plan
- Reset and idle: hold RST_N=0 with FRAME=12'hFC0 and no START, then release. Required: all outputs 0 for 50 cycles and no BITSLIP.
- Aligned lock: FRAME=12'hFC0 constant, START pulse at edge k. Required: LOCKED=1 from edge k+20, SLIP_CNT=0, zero BITSLIP pulses, BUSY=0 once locked.
- Slip search: bench model rotates FRAME by 2 bits per BITSLIP, starting 3 slips from PATTERN. Required: exactly 3 single-cycle pulses, 6 cycles apart, then LOCKED=1 and SLIP_CNT=3.
- Exhaustion: FRAME=12'h000 constant. Required: 12 pulses, then FAIL=1, LOCKED=0, BUSY=0, SLIP_CNT=12. A later START clears FAIL and restarts the search.
- Loss of lock: once locked, inject 3 mismatching words then PATTERN. Required: LOCKED stays 1. Then inject 4 consecutive mismatches. Required: LOCKED=0 at the 4th, SLIP_CNT=0, and a new search begins.
- Mid-operation events: START pulse during SLIP. Required: BITSLIP low next cycle and counters cleared. Then assert RST_N=0 asynchronously mid-WAIT. Required: outputs 0 immediately and state IDLE.
